// File: rtl/vanilla_sb_clear_arbiter_if.sv
// Scoreboard-clear bus between writeback requesters and the clear arbiter.
// The requester side drives valid/class/id and the freeze enable; the
// arbiter side returns grants, the two clear ports and contention counters.
interface vanilla_sb_clear_arbiter_if #(
   parameter int els_p            = 4,
   parameter int reg_addr_width_p = 5,
   parameter int ctr_width_p      = 32
);
   logic                                 clear_en_i;
   logic [els_p-1:0]                     v_i;
   logic [els_p-1:0]                     is_float_i;
   logic [els_p*reg_addr_width_p-1:0]    id_i;
   logic [els_p-1:0]                     yumi_o;
   logic                                 int_sb_clear_o;
   logic [reg_addr_width_p-1:0]          int_sb_clear_id_o;
   logic                                 float_sb_clear_o;
   logic [reg_addr_width_p-1:0]          float_sb_clear_id_o;
   logic [ctr_width_p-1:0]               int_conflict_ctr_o;
   logic [ctr_width_p-1:0]               float_conflict_ctr_o;

   // Requester / stimulus side.
   modport master (
      output clear_en_i, v_i, is_float_i, id_i,
      input  yumi_o, int_sb_clear_o, int_sb_clear_id_o,
             float_sb_clear_o, float_sb_clear_id_o,
             int_conflict_ctr_o, float_conflict_ctr_o
   );

   // Arbiter side.
   modport slave (
      input  clear_en_i, v_i, is_float_i, id_i,
      output yumi_o, int_sb_clear_o, int_sb_clear_id_o,
             float_sb_clear_o, float_sb_clear_id_o,
             int_conflict_ctr_o, float_conflict_ctr_o
   );
endinterface

// File: rtl/vanilla_sb_clear_arbiter.sv
// Scoreboard clear arbiter for the vanilla core.
// Several writeback sources compete for one integer and one float scoreboard
// clear port. Each class has an independent round-robin pointer; at most one
// integer and one float grant are made per cycle. Clear strobes and ids are
// registered, so a clear appears one cycle after its grant. Integer x0 is
// granted (consumed) but never produces a clear strobe. Saturating counters
// record cycles where a class had more than one candidate.
module vanilla_sb_clear_arbiter #(
   parameter int els_p            = 4,
   parameter int reg_addr_width_p = 5,
   parameter int ctr_width_p      = 32
) (
   input logic                          clk_i,
   input logic                          reset_n_i,
   vanilla_sb_clear_arbiter_if.slave    bus
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

   typedef logic [ptr_w_lp-1:0]         ptr_t;
   typedef logic [reg_addr_width_p-1:0] rid_t;

   // Round-robin pointers (next index with highest priority).
   ptr_t                 rr_int_r;
   ptr_t                 rr_fp_r;

   // Registered clear port state.
   logic                 int_clear_r;
   rid_t                 int_id_r;
   logic                 fp_clear_r;
   rid_t                 fp_id_r;

   // Contention counters.
   logic [ctr_width_p-1:0] int_ctr_r;
   logic [ctr_width_p-1:0] fp_ctr_r;

   // Combinational arbitration results.
   logic [els_p-1:0]     int_cand_s;
   logic [els_p-1:0]     fp_cand_s;
   logic [els_p-1:0]     int_grant_s;
   logic [els_p-1:0]     fp_grant_s;
   logic                 int_found_s;
   logic                 fp_found_s;
   ptr_t                 int_win_s;
   ptr_t                 fp_win_s;
   rid_t                 id_arr_s [els_p];
   rid_t                 int_win_id_s;
   rid_t                 fp_win_id_s;
   logic                 int_conflict_s;
   logic                 fp_conflict_s;

   // Index reached by stepping i positions past ptr, wrapping at els_p.
   function automatic ptr_t wrap_idx(input ptr_t ptr, input int i);
      int sum;
      sum = (int'(ptr) + i) % els_p;
      return ptr_t'(sum);
   endfunction

   // Pointer value after a grant to win: one past the winner, wrapping.
   function automatic ptr_t next_ptr(input ptr_t win);
      ptr_t nxt;
      if (win == ptr_t'(els_p - 1)) begin
         nxt = ptr_t'(0);
      end else begin
         nxt = win + ptr_t'(1);
      end
      return nxt;
   endfunction

   // True when at least two bits of the candidate vector are set.
   function automatic logic multi_hot(input logic [els_p-1:0] vec);
      return |(vec & (vec - {{(els_p-1){1'b0}}, 1'b1}));
   endfunction

   // Unpack the flat id bus into per-requester ids.
   always_comb begin
      for (int k = 0; k < els_p; k++) begin
         id_arr_s[k] = bus.id_i[k*reg_addr_width_p +: reg_addr_width_p];
      end
   end

   // Split requests into integer and float candidate sets; frozen when disabled.
   always_comb begin
      if (bus.clear_en_i && reset_n_i) begin
         int_cand_s = bus.v_i & ~bus.is_float_i;
         fp_cand_s  = bus.v_i &  bus.is_float_i;
      end else begin
         int_cand_s = '0;
         fp_cand_s  = '0;
      end
   end

   // Integer round-robin: first candidate at or after rr_int_r, wrapping.
   always_comb begin
      ptr_t j;
      int_found_s = 1'b0;
      int_win_s   = '0;
      int_grant_s = '0;
      for (int i = 0; i < els_p; i++) begin
         j = wrap_idx(rr_int_r, i);
         if (!int_found_s && int_cand_s[j]) begin
            int_found_s    = 1'b1;
            int_win_s      = j;
            int_grant_s[j] = 1'b1;
         end else begin
            int_found_s = int_found_s;
         end
      end
   end

   // Float round-robin: first candidate at or after rr_fp_r, wrapping.
   always_comb begin
      ptr_t j;
      fp_found_s = 1'b0;
      fp_win_s   = '0;
      fp_grant_s = '0;
      for (int i = 0; i < els_p; i++) begin
         j = wrap_idx(rr_fp_r, i);
         if (!fp_found_s && fp_cand_s[j]) begin
            fp_found_s    = 1'b1;
            fp_win_s      = j;
            fp_grant_s[j] = 1'b1;
         end else begin
            fp_found_s = fp_found_s;
         end
      end
   end

   // Winner ids and per-class contention detection.
   always_comb begin
      int_win_id_s   = id_arr_s[int_win_s];
      fp_win_id_s    = id_arr_s[fp_win_s];
      int_conflict_s = multi_hot(int_cand_s);
      fp_conflict_s  = multi_hot(fp_cand_s);
   end

   // Grants back to requesters; candidates are already empty in reset/freeze.
   always_comb begin
      bus.yumi_o = int_grant_s | fp_grant_s;
   end

   // Round-robin pointers advance past each class winner, hold otherwise.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_int_r <= '0;
         rr_fp_r  <= '0;
      end else begin
         if (int_found_s) begin
            rr_int_r <= next_ptr(int_win_s);
         end else begin
            rr_int_r <= rr_int_r;
         end
         if (fp_found_s) begin
            rr_fp_r <= next_ptr(fp_win_s);
         end else begin
            rr_fp_r <= rr_fp_r;
         end
      end
   end

   // Clear port registers: strobe for one cycle per grant, id held when idle;
   // integer x0 is consumed without a strobe since x0 is never scoreboarded.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         int_clear_r <= 1'b0;
         int_id_r    <= '0;
         fp_clear_r  <= 1'b0;
         fp_id_r     <= '0;
      end else begin
         if (int_found_s) begin
            int_clear_r <= (int_win_id_s != rid_t'(0));
            int_id_r    <= int_win_id_s;
         end else begin
            int_clear_r <= 1'b0;
            int_id_r    <= int_id_r;
         end
         if (fp_found_s) begin
            fp_clear_r <= 1'b1;
            fp_id_r    <= fp_win_id_s;
         end else begin
            fp_clear_r <= 1'b0;
            fp_id_r    <= fp_id_r;
         end
      end
   end

   // Saturating contention counters for the profiler.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         int_ctr_r <= '0;
         fp_ctr_r  <= '0;
      end else begin
         if (int_conflict_s && !(&int_ctr_r)) begin
            int_ctr_r <= int_ctr_r + {{(ctr_width_p-1){1'b0}}, 1'b1};
         end else begin
            int_ctr_r <= int_ctr_r;
         end
         if (fp_conflict_s && !(&fp_ctr_r)) begin
            fp_ctr_r <= fp_ctr_r + {{(ctr_width_p-1){1'b0}}, 1'b1};
         end else begin
            fp_ctr_r <= fp_ctr_r;
         end
      end
   end

   // Drive registered state onto the bus.
   always_comb begin
      bus.int_sb_clear_o       = int_clear_r;
      bus.int_sb_clear_id_o    = int_id_r;
      bus.float_sb_clear_o     = fp_clear_r;
      bus.float_sb_clear_id_o  = fp_id_r;
      bus.int_conflict_ctr_o   = int_ctr_r;
      bus.float_conflict_ctr_o = fp_ctr_r;
   end

endmodule

// File: tb/tb_vanilla_sb_clear_arbiter.sv
// Scoreboard bench for vanilla_sb_clear_arbiter (4 requesters, 5-bit ids,
// 4-bit counters so saturation is reachable).
module tb_vanilla_sb_clear_arbiter;

   localparam int ELS = 4;
   localparam int RW  = 5;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;

   always #5 clk_i = ~clk_i;

   vanilla_sb_clear_arbiter_if #(.els_p(ELS), .reg_addr_width_p(RW), .ctr_width_p(CW)) bus ();

   vanilla_sb_clear_arbiter #(.els_p(ELS), .reg_addr_width_p(RW), .ctr_width_p(CW)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   typedef struct {
      logic          ic;
      logic [RW-1:0] iid;
      logic          fc;
      logic [RW-1:0] fid;
      int            ictr;
      int            fctr;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference state
   int m_pi, m_pf, m_ictr, m_fctr;
   logic [RW-1:0] m_iid, m_fid;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic logic [ELS*RW-1:0] mk_ids(input int a, input int b, input int c, input int d);
      logic [RW-1:0] ra, rb, rc, rd;
      ra = RW'(a); rb = RW'(b); rc = RW'(c); rd = RW'(d);
      return {rd, rc, rb, ra};
   endfunction

   function automatic int rr_model(input logic [ELS-1:0] cand, input int ptr);
      int win = -1;
      for (int i = 0; i < ELS; i++) begin
         int j = (ptr + i) % ELS;
         if (win < 0 && cand[j]) win = j;
      end
      return win;
   endfunction

   function automatic int popc(input logic [ELS-1:0] x);
      int c = 0;
      for (int i = 0; i < ELS; i++) c += int'(x[i]);
      return c;
   endfunction

   task automatic model_reset();
      m_pi = 0; m_pf = 0; m_ictr = 0; m_fctr = 0; m_iid = '0; m_fid = '0;
   endtask

   // One cycle: drive, check yumi, push expected clear state, clock, pop and compare.
   task automatic step(input logic en, input logic [ELS-1:0] v, input logic [ELS-1:0] isf,
                       input logic [ELS*RW-1:0] ids);
      logic [ELS-1:0] ci, cf, ey;
      logic [RW-1:0]  idw;
      int wi, wf;
      exp_t e, o;
      bus.clear_en_i = en;
      bus.v_i        = v;
      bus.is_float_i = isf;
      bus.id_i       = ids;
      #1;
      ci = v & ~isf;
      cf = v & isf;
      wi = -1; wf = -1; ey = '0;
      if (en) begin
         wi = rr_model(ci, m_pi);
         wf = rr_model(cf, m_pf);
         if (popc(ci) >= 2 && m_ictr < CMAX) m_ictr++;
         if (popc(cf) >= 2 && m_fctr < CMAX) m_fctr++;
      end
      if (wi >= 0) ey[wi] = 1'b1;
      if (wf >= 0) ey[wf] = 1'b1;
      check_eq("yumi", 32'(bus.yumi_o), 32'(ey));
      e.ic = 1'b0; e.fc = 1'b0;
      if (wi >= 0) begin
         idw = ids[wi*RW +: RW];
         e.ic = (idw != '0);
         m_iid = idw;
         m_pi = (wi + 1) % ELS;
      end
      if (wf >= 0) begin
         e.fc = 1'b1;
         m_fid = ids[wf*RW +: RW];
         m_pf = (wf + 1) % ELS;
      end
      e.iid = m_iid; e.fid = m_fid; e.ictr = m_ictr; e.fctr = m_fctr;
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) begin
         o = sb_q.pop_front();
         check_eq("int_clear", 32'(bus.int_sb_clear_o), 32'(o.ic));
         check_eq("int_id", 32'(bus.int_sb_clear_id_o), 32'(o.iid));
         check_eq("fp_clear", 32'(bus.float_sb_clear_o), 32'(o.fc));
         check_eq("fp_id", 32'(bus.float_sb_clear_id_o), 32'(o.fid));
         check_eq("int_ctr", 32'(bus.int_conflict_ctr_o), 32'(o.ictr));
         check_eq("fp_ctr", 32'(bus.float_conflict_ctr_o), 32'(o.fctr));
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_yumi"}, 32'(bus.yumi_o), 32'd0);
      check_eq({tag, "_int_clear"}, 32'(bus.int_sb_clear_o), 32'd0);
      check_eq({tag, "_int_id"}, 32'(bus.int_sb_clear_id_o), 32'd0);
      check_eq({tag, "_fp_clear"}, 32'(bus.float_sb_clear_o), 32'd0);
      check_eq({tag, "_fp_id"}, 32'(bus.float_sb_clear_id_o), 32'd0);
      check_eq({tag, "_int_ctr"}, 32'(bus.int_conflict_ctr_o), 32'd0);
      check_eq({tag, "_fp_ctr"}, 32'(bus.float_conflict_ctr_o), 32'd0);
   endtask

   initial begin
      bus.clear_en_i = 1'b1;
      bus.v_i        = 4'b1111;
      bus.is_float_i = 4'b0101;
      bus.id_i       = mk_ids(3, 4, 5, 6);
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_state("por");
      reset_n_i = 1'b1;

      // round-robin rotation, all integer requesters valid
      for (int c = 0; c < 5; c++) step(1'b1, 4'b1111, 4'b0000, mk_ids(1, 2, 3, 4));
      check_eq("rr_ctr_after5", 32'(bus.int_conflict_ctr_o), 32'd5);
      step(1'b1, 4'b0000, 4'b0000, '0);

      // single request
      step(1'b1, 4'b0100, 4'b0000, mk_ids(0, 0, 7, 0));
      step(1'b1, 4'b0000, 4'b0000, mk_ids(0, 0, 7, 0));

      // mixed classes in one cycle
      step(1'b1, 4'b0011, 4'b0010, mk_ids(5, 9, 0, 0));
      step(1'b1, 4'b0000, 4'b0000, '0);

      // integer x0 consumed without strobe; float f0 cleared
      step(1'b1, 4'b0001, 4'b0000, mk_ids(0, 0, 0, 0));
      step(1'b1, 4'b1000, 4'b1000, mk_ids(0, 0, 0, 0));

      // freeze with three requests, then resume from held pointer
      step(1'b0, 4'b0111, 4'b0000, mk_ids(11, 12, 13, 0));
      step(1'b0, 4'b0111, 4'b0000, mk_ids(11, 12, 13, 0));
      step(1'b1, 4'b0111, 4'b0000, mk_ids(11, 12, 13, 0));
      step(1'b1, 4'b0111, 4'b0000, mk_ids(11, 12, 13, 0));

      // random traffic across both classes, with occasional freeze
      for (int c = 0; c < 40; c++) begin
         step(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), (ELS*RW)'({$urandom, $urandom}));
      end

      // asynchronous reset while an integer clear is showing
      step(1'b1, 4'b0100, 4'b0000, mk_ids(0, 0, 7, 0));
      check_eq("pre_rst_int_clear", 32'(bus.int_sb_clear_o), 32'd1);
      bus.v_i = 4'b1001; bus.is_float_i = 4'b0000; bus.id_i = mk_ids(2, 0, 0, 8);
      #2;
      reset_n_i = 1'b0;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      step(1'b1, 4'b1001, 4'b0000, mk_ids(2, 0, 0, 8));
      step(1'b1, 4'b1000, 4'b0000, mk_ids(2, 0, 0, 8));

      // saturation: two integer and two float requesters for 20 cycles
      for (int c = 0; c < 20; c++) step(1'b1, 4'b1111, 4'b1100, mk_ids(1, 2, 3, 4));
      check_eq("int_ctr_sat", 32'(bus.int_conflict_ctr_o), 32'(CMAX));
      check_eq("fp_ctr_sat", 32'(bus.float_conflict_ctr_o), 32'(CMAX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
